// File: rtl/exec_unit_seq.sv
// Execute stage: register file, ALU and move path behind one valid/ready issue port.
// Shifts run either as one barrel step or one bit per cycle, back-pressuring decode.
module exec_unit_seq #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 16,
    parameter int IMMW         = 16,
    parameter bit SERIAL_SHIFT = 1'b1,
    localparam int RAW         = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    // Issue handshake: an instruction moves on any rising edge where in_valid and
    // in_ready are both high; with either low, the issue fields are ignored.
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      pfix,
    input  logic [5:0]      opcode,
    input  logic [RAW-1:0]  rs,
    input  logic [RAW-1:0]  rd,
    input  logic [IMMW-1:0] imm,
    output logic            out_valid,
    output logic [RAW-1:0]  out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_illegal,
    input  logic [RAW-1:0]  dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    output logic            dbg_state
);

    localparam int              CW     = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] XLEN_V = XLEN'(XLEN);

    localparam logic [5:0] OP_MV  = 6'b000011;
    localparam logic [5:0] OP_ADD = 6'b000100;
    localparam logic [5:0] OP_SUB = 6'b000101;
    localparam logic [5:0] OP_SHR = 6'b000110;
    localparam logic [5:0] OP_SHL = 6'b000111;
    localparam logic [5:0] OP_AND = 6'b001000;
    localparam logic [5:0] OP_OR  = 6'b001001;
    localparam logic [5:0] OP_XOR = 6'b001010;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] sh_val_q;
    logic [CW-1:0]   sh_cnt_q;
    logic            sh_left_q;
    logic [RAW-1:0]  sh_rd_q;
    logic            out_valid_q;
    logic [RAW-1:0]  out_rd_q;
    logic [XLEN-1:0] out_data_q;
    logic            out_illegal_q;

    logic [XLEN-1:0] src_d;
    logic [XLEN-1:0] dst_d;
    logic [XLEN-1:0] alu_d;
    logic            legal_d;
    logic            shift_d;
    logic            left_d;
    logic            big_d;
    logic            serial_go_d;
    logic [CW-1:0]   cnt_init_d;
    logic [XLEN-1:0] sh_val_d;
    logic            transfer;

    assign in_ready    = (state_q == S_IDLE) & ~rst;
    assign transfer    = in_valid & in_ready;
    assign out_valid   = out_valid_q;
    assign out_rd      = out_rd_q;
    assign out_data    = out_data_q;
    assign out_illegal = out_illegal_q;
    assign dbg_rdata   = regs_q[dbg_raddr];
    assign dbg_state   = state_q;

    always_comb begin
        src_d   = (pfix == 2'b11) ? XLEN'(imm) : regs_q[rs];
        dst_d   = regs_q[rd];
        big_d   = (src_d >= XLEN_V);
        legal_d = 1'b1;
        shift_d = 1'b0;
        left_d  = 1'b0;
        alu_d   = '0;
        case (opcode)
            OP_MV:  alu_d = src_d;
            OP_ADD: alu_d = dst_d + src_d;
            OP_SUB: alu_d = dst_d - src_d;
            OP_SHR: begin
                shift_d = 1'b1;
                alu_d   = big_d ? '0 : (dst_d >> src_d);
            end
            OP_SHL: begin
                shift_d = 1'b1;
                left_d  = 1'b1;
                alu_d   = big_d ? '0 : (dst_d << src_d);
            end
            OP_AND: alu_d = dst_d & src_d;
            OP_OR:  alu_d = dst_d | src_d;
            OP_XOR: alu_d = dst_d ^ src_d;
            default: legal_d = 1'b0;
        endcase
        // A zero-amount shift has nothing to iterate over, so it retires like any ALU op.
        serial_go_d = SERIAL_SHIFT && shift_d && (src_d != '0);
        cnt_init_d  = big_d ? CW'(XLEN) : CW'(src_d);
        sh_val_d    = sh_left_q ? (sh_val_q << 1) : (sh_val_q >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            sh_val_q      <= '0;
            sh_cnt_q      <= '0;
            sh_left_q     <= 1'b0;
            sh_rd_q       <= '0;
            out_valid_q   <= 1'b0;
            out_rd_q      <= '0;
            out_data_q    <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (transfer) begin
                        if (serial_go_d) begin
                            sh_val_q  <= dst_d;
                            sh_cnt_q  <= cnt_init_d;
                            sh_left_q <= left_d;
                            sh_rd_q   <= rd;
                            state_q   <= S_SHIFT;
                        end else begin
                            if (legal_d) regs_q[rd] <= alu_d;
                            out_valid_q   <= 1'b1;
                            out_rd_q      <= rd;
                            out_data_q    <= legal_d ? alu_d : '0;
                            out_illegal_q <= ~legal_d;
                        end
                    end
                end
                S_SHIFT: begin
                    sh_val_q <= sh_val_d;
                    sh_cnt_q <= sh_cnt_q - CW'(1);
                    if (sh_cnt_q == CW'(1)) begin
                        regs_q[sh_rd_q] <= sh_val_d;
                        out_valid_q     <= 1'b1;
                        out_rd_q        <= sh_rd_q;
                        out_data_q      <= sh_val_d;
                        out_illegal_q   <= 1'b0;
                        state_q         <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit_seq.sv
// Bench for exec_unit_seq: unit 0 uses the serial shifter, unit 1 the barrel shifter.
// Both are checked against a plain-arithmetic register-file model.
module tb_exec_unit_seq;

    localparam int NREGS = 16;

    localparam logic [5:0] OP_MV  = 6'b000011;
    localparam logic [5:0] OP_ADD = 6'b000100;
    localparam logic [5:0] OP_SUB = 6'b000101;
    localparam logic [5:0] OP_SHR = 6'b000110;
    localparam logic [5:0] OP_SHL = 6'b000111;
    localparam logic [5:0] OP_AND = 6'b001000;
    localparam logic [5:0] OP_OR  = 6'b001001;
    localparam logic [5:0] OP_XOR = 6'b001010;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [1:0]  pfix      [2];
    logic [5:0]  opcode    [2];
    logic [3:0]  rs        [2];
    logic [3:0]  rd        [2];
    logic [15:0] imm       [2];
    logic        out_valid [2];
    logic [3:0]  out_rd    [2];
    logic [31:0] out_data  [2];
    logic        out_illegal [2];
    logic [3:0]  dbg_raddr [2];
    logic [31:0] dbg_rdata [2];
    logic        dbg_state [2];

    logic [31:0] model_q [2][NREGS];
    logic [5:0]  op_tab [10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          last_lat;

    always #5 clk = ~clk;

    exec_unit_seq #(.XLEN(32), .NREGS(16), .IMMW(16), .SERIAL_SHIFT(1'b1)) dut_ser (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .pfix(pfix[0]), .opcode(opcode[0]), .rs(rs[0]), .rd(rd[0]), .imm(imm[0]),
        .out_valid(out_valid[0]), .out_rd(out_rd[0]), .out_data(out_data[0]),
        .out_illegal(out_illegal[0]), .dbg_raddr(dbg_raddr[0]), .dbg_rdata(dbg_rdata[0]),
        .dbg_state(dbg_state[0])
    );

    exec_unit_seq #(.XLEN(32), .NREGS(16), .IMMW(16), .SERIAL_SHIFT(1'b0)) dut_bar (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .pfix(pfix[1]), .opcode(opcode[1]), .rs(rs[1]), .rd(rd[1]), .imm(imm[1]),
        .out_valid(out_valid[1]), .out_rd(out_rd[1]), .out_data(out_data[1]),
        .out_illegal(out_illegal[1]), .dbg_raddr(dbg_raddr[1]), .dbg_rdata(dbg_rdata[1]),
        .dbg_state(dbg_state[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] d,
                                            input logic [31:0] s, output logic legal);
        logic [31:0] r;
        legal = 1'b1;
        r     = 32'd0;
        case (op)
            OP_MV:  r = s;
            OP_ADD: r = d + s;
            OP_SUB: r = d - s;
            OP_SHR: r = (s >= 32) ? 32'd0 : (d >> s);
            OP_SHL: r = (s >= 32) ? 32'd0 : (d << s);
            OP_AND: r = d & s;
            OP_OR:  r = d | s;
            OP_XOR: r = d ^ s;
            default: legal = 1'b0;
        endcase
        return r;
    endfunction

    task automatic read_reg(input int u, input int r, output logic [31:0] v);
        dbg_raddr[u] = 4'(r);
        #1;
        v = dbg_rdata[u];
    endtask

    task automatic check_reg(input int u, input int r, input logic [31:0] exp, input string name);
        logic [31:0] v;
        read_reg(u, r, v);
        check_eq($sformatf("%s_u%0d", name, u), v, exp);
    endtask

    task automatic check_all_regs(input int u, input string name);
        logic [31:0] v;
        for (int r = 0; r < NREGS; r++) begin
            read_reg(u, r, v);
            check_eq($sformatf("%s_u%0d_r%0d", name, u, r), v, model_q[u][r]);
        end
    endtask

    // Issues one instruction from idle and follows it to retirement.
    task automatic issue(input int u, input logic [1:0] pf, input logic [5:0] op,
                         input logic [3:0] rs_v, input logic [3:0] rd_v, input logic [15:0] im);
        logic [31:0] s, d, exp_res, v;
        logic        legal;
        int          exp_lat, lat, low_cycles;
        s       = (pf == 2'b11) ? {16'h0000, im} : model_q[u][rs_v];
        d       = model_q[u][rd_v];
        exp_res = ref_alu(op, d, s, legal);
        exp_lat = 1;
        if (u == 0 && legal && (op == OP_SHR || op == OP_SHL) && s != 32'd0)
            exp_lat = 1 + ((s >= 32) ? 32 : int'(s));
        @(negedge clk);
        check_eq($sformatf("ready_u%0d", u), 32'(in_ready[u]), 32'd1);
        in_valid[u] = 1'b1;
        pfix[u]     = pf;
        opcode[u]   = op;
        rs[u]       = rs_v;
        rd[u]       = rd_v;
        imm[u]      = im;
        @(negedge clk);
        in_valid[u] = 1'b0;
        opcode[u]   = 6'($urandom);
        imm[u]      = 16'($urandom);
        lat         = 1;
        low_cycles  = 0;
        while (out_valid[u] !== 1'b1 && lat < 64) begin
            if (in_ready[u] === 1'b0) low_cycles++;
            @(negedge clk);
            lat++;
        end
        last_lat = lat;
        check_eq($sformatf("latency_u%0d_op%0h", u, op), 32'(lat), 32'(exp_lat));
        check_eq($sformatf("ready_low_u%0d", u), 32'(low_cycles), 32'(exp_lat - 1));
        check_eq($sformatf("out_rd_u%0d", u), 32'(out_rd[u]), 32'(rd_v));
        check_eq($sformatf("out_data_u%0d_op%0h", u, op), out_data[u], legal ? exp_res : 32'd0);
        check_eq($sformatf("out_illegal_u%0d", u), 32'(out_illegal[u]), 32'(!legal));
        if (legal) model_q[u][rd_v] = exp_res;
        read_reg(u, rd_v, v);
        check_eq($sformatf("wb_u%0d_r%0d", u, rd_v), v, model_q[u][rd_v]);
        @(negedge clk);
        check_eq($sformatf("pulse_u%0d", u), 32'(out_valid[u]), 32'd0);
    endtask

    task automatic test_b2b(input int u);
        @(negedge clk);
        in_valid[u] = 1'b1;
        pfix[u]     = 2'b11;
        opcode[u]   = OP_MV;
        rs[u]       = 4'd0;
        rd[u]       = 4'd1;
        imm[u]      = 16'hFFFF;
        @(negedge clk);
        check_eq($sformatf("b2b_ready_u%0d", u), 32'(in_ready[u]), 32'd1);
        check_eq($sformatf("b2b_ov1_u%0d", u), 32'(out_valid[u]), 32'd1);
        check_eq($sformatf("b2b_data1_u%0d", u), out_data[u], 32'h0000_FFFF);
        opcode[u] = OP_ADD;
        imm[u]    = 16'h0001;
        @(negedge clk);
        in_valid[u] = 1'b0;
        check_eq($sformatf("b2b_ov2_u%0d", u), 32'(out_valid[u]), 32'd1);
        check_eq($sformatf("b2b_data2_u%0d", u), out_data[u], 32'h0001_0000);
        model_q[u][1] = 32'h0001_0000;
        @(negedge clk);
        check_eq($sformatf("b2b_ov3_u%0d", u), 32'(out_valid[u]), 32'd0);
        check_reg(u, 1, 32'h0001_0000, "b2b_r1");
    endtask

    task automatic run_directed(input int u);
        test_b2b(u);
        issue(u, 2'b11, OP_MV, 4'd0, 4'd2, 16'hFFFF);
        issue(u, 2'b11, OP_SHL, 4'd0, 4'd2, 16'd16);
        issue(u, 2'b11, OP_OR, 4'd0, 4'd2, 16'hFFFF);
        check_reg(u, 2, 32'hFFFF_FFFF, "r2_all_ones");
        issue(u, 2'b11, OP_ADD, 4'd0, 4'd2, 16'd1);
        check_reg(u, 2, 32'h0000_0000, "r2_wrap");
        issue(u, 2'b11, OP_MV, 4'd0, 4'd4, 16'd5);
        issue(u, 2'b11, OP_SUB, 4'd0, 4'd4, 16'd7);
        check_reg(u, 4, 32'hFFFF_FFFE, "r4_borrow");
        issue(u, 2'b11, OP_MV, 4'd0, 4'd6, 16'h8000);
        issue(u, 2'b11, OP_SHL, 4'd0, 4'd6, 16'd16);
        issue(u, 2'b11, OP_MV, 4'd0, 4'd5, 16'd1);
        issue(u, 2'b00, OP_OR, 4'd6, 4'd5, 16'h0);
        check_reg(u, 5, 32'h8000_0001, "r5_setup");
        issue(u, 2'b11, OP_SHR, 4'd0, 4'd5, 16'd4);
        check_eq($sformatf("shr4_lat_u%0d", u), 32'(last_lat), (u == 0) ? 32'd5 : 32'd1);
        check_reg(u, 5, 32'h0800_0000, "r5_shr4");
        issue(u, 2'b11, OP_SHL, 4'd0, 4'd5, 16'd40);
        check_eq($sformatf("shl40_lat_u%0d", u), 32'(last_lat), (u == 0) ? 32'd33 : 32'd1);
        check_reg(u, 5, 32'h0000_0000, "r5_shl40");
        issue(u, 2'b11, OP_SHR, 4'd0, 4'd4, 16'd0);
        check_eq($sformatf("shr0_lat_u%0d", u), 32'(last_lat), 32'd1);
        issue(u, 2'b11, OP_MV, 4'd0, 4'd3, 16'h1234);
        issue(u, 2'b00, OP_SUB, 4'd3, 4'd3, 16'h0);
        check_reg(u, 3, 32'h0000_0000, "r3_self_sub");
        issue(u, 2'b11, 6'b111111, 4'd0, 4'd7, 16'h0055);
        check_all_regs(u, "after_illegal");
    endtask

    task automatic test_reset_mid_shift();
        logic saw_ov;
        issue(0, 2'b11, OP_MV, 4'd0, 4'd5, 16'h00FF);
        @(negedge clk);
        in_valid[0] = 1'b1;
        pfix[0]     = 2'b11;
        opcode[0]   = OP_SHR;
        rd[0]       = 4'd5;
        imm[0]      = 16'd4;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("mid_shift_state", 32'(dbg_state[0]), 32'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        check_eq("rst_ready_low", 32'(in_ready[0]), 32'd0);
        rst[0] = 1'b0;
        for (int r = 0; r < NREGS; r++) model_q[0][r] = 32'd0;
        saw_ov = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) saw_ov = 1'b1;
        end
        check_eq("abort_no_out_valid", 32'(saw_ov), 32'd0);
        check_eq("abort_state_idle", 32'(dbg_state[0]), 32'd0);
        check_eq("abort_ready", 32'(in_ready[0]), 32'd1);
        check_reg(0, 5, 32'd0, "abort_r5");
        check_all_regs(0, "abort");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  pf;
        logic [5:0]  op;
        logic [15:0] im;
        op_tab[0] = OP_MV;  op_tab[1] = OP_ADD; op_tab[2] = OP_SUB; op_tab[3] = OP_SHR;
        op_tab[4] = OP_SHL; op_tab[5] = OP_AND; op_tab[6] = OP_OR;  op_tab[7] = OP_XOR;
        op_tab[8] = 6'b111111; op_tab[9] = 6'b000000;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; in_valid[u] = 1'b0; pfix[u] = 2'b00; opcode[u] = 6'd0;
            rs[u] = 4'd0; rd[u] = 4'd0; imm[u] = 16'd0; dbg_raddr[u] = 4'd0;
            for (int r = 0; r < NREGS; r++) model_q[u][r] = 32'd0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_eq($sformatf("rst_ready_u%0d", u), 32'(in_ready[u]), 32'd0);
            check_eq($sformatf("rst_out_valid_u%0d", u), 32'(out_valid[u]), 32'd0);
            check_eq($sformatf("rst_out_data_u%0d", u), out_data[u], 32'd0);
            check_eq($sformatf("rst_out_rd_u%0d", u), 32'(out_rd[u]), 32'd0);
            check_eq($sformatf("rst_out_illegal_u%0d", u), 32'(out_illegal[u]), 32'd0);
            rst[u] = 1'b0;
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_eq($sformatf("post_rst_ready_u%0d", u), 32'(in_ready[u]), 32'd1);
            check_all_regs(u, "post_rst");
        end
        run_directed(0);
        run_directed(1);
        test_reset_mid_shift();
        for (int k = 0; k < 80; k++) begin
            for (int u = 0; u < 2; u++) begin
                pf = 2'($urandom_range(0, 3));
                op = op_tab[$urandom_range(0, 9)];
                im = 16'($urandom);
                if ((op == OP_SHR || op == OP_SHL) && pf == 2'b11)
                    im = 16'($urandom_range(0, 40));
                issue(u, pf, op, 4'($urandom), 4'($urandom), im);
            end
        end
        check_all_regs(0, "final");
        check_all_regs(1, "final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
